// File: rtl/alu_result_stage.sv
// Execute-to-memory result stage: 2-entry skid buffer holding ALU result, tag and flags.
// Optional decode-stage forwarding lookup enabled by defining ALU_STAGE_FWD_EN.
module alu_result_stage #(
   parameter int N    = 8,
   parameter int RD_W = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N-1:0]    in_result,
   input  logic [3:0]      in_op,
   input  logic [RD_W-1:0] in_rd,
   input  logic            in_wb_en,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [N-1:0]    out_result,
   output logic [3:0]      out_op,
   output logic [RD_W-1:0] out_rd,
   output logic            out_wb_en,
   output logic            out_zero,
   output logic            out_neg
`ifdef ALU_STAGE_FWD_EN
   ,
   input  logic [RD_W-1:0] fwd_rd,
   output logic            fwd_hit,
   output logic [N-1:0]    fwd_data
`endif
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   typedef struct packed {
      logic [N-1:0]    result;
      logic [3:0]      op;
      logic [RD_W-1:0] rd;
      logic            wb_en;
      logic            zero;
      logic            neg;
   } entry_t;

   state_t state_q, state_d;
   entry_t head_q, head_d;
   entry_t skid_q, skid_d;
   entry_t new_entry;
   logic   accept;
   logic   pop;

   assign in_ready  = (state_q != S_FULL);
   assign out_valid = (state_q != S_EMPTY);

   assign out_result = head_q.result;
   assign out_op     = head_q.op;
   assign out_rd     = head_q.rd;
   assign out_wb_en  = head_q.wb_en;
   assign out_zero   = head_q.zero;
   assign out_neg    = head_q.neg;

   always_comb begin
      new_entry.result = in_result;
      new_entry.op     = in_op;
      new_entry.rd     = in_rd;
      new_entry.wb_en  = in_wb_en;
      new_entry.zero   = (in_result == '0);
      new_entry.neg    = in_result[N-1];
   end

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      skid_d  = skid_q;
      accept  = in_valid && in_ready;
      pop     = out_valid && out_ready;

      if (flush) begin
         // Clearing payload keeps out_* at zero whenever the stage is empty.
         state_d = S_EMPTY;
         head_d  = '0;
         skid_d  = '0;
      end else begin
         unique case (state_q)
            S_EMPTY: begin
               if (accept) begin
                  state_d = S_ONE;
                  head_d  = new_entry;
               end
            end
            S_ONE: begin
               if (accept && pop) begin
                  head_d = new_entry;
               end else if (accept) begin
                  state_d = S_FULL;
                  skid_d  = new_entry;
               end else if (pop) begin
                  state_d = S_EMPTY;
                  head_d  = '0;
               end
            end
            S_FULL: begin
               if (pop) begin
                  state_d = S_ONE;
                  head_d  = skid_q;
                  skid_d  = '0;
               end
            end
            default: begin
               state_d = S_EMPTY;
               head_d  = '0;
               skid_d  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_EMPTY;
         head_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         skid_q  <= skid_d;
      end
   end

`ifdef ALU_STAGE_FWD_EN
   // Skid holds the younger result, so it wins over the head.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      if (fwd_rd != '0) begin
         if ((state_q == S_FULL) && skid_q.wb_en && (skid_q.rd == fwd_rd)) begin
            fwd_hit  = 1'b1;
            fwd_data = skid_q.result;
         end else if ((state_q != S_EMPTY) && head_q.wb_en && (head_q.rd == fwd_rd)) begin
            fwd_hit  = 1'b1;
            fwd_data = head_q.result;
         end
      end
   end
`endif

endmodule
